// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory request/response and decode handshake bundle
interface pc_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and fetch sequencer presenting instructions to decode
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_fetch_unit_if.master        bus,
    input  logic [31:0]            next_pc,
    input  logic                   halt,
    output logic                   halted,
    output logic                   misalign_err,
    output logic [31:0]            instret
);
    typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_DELIV, S_HALTED, S_ERR} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic        req_valid_q, req_valid_d;
    logic        inst_valid_q, inst_valid_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        case (state_q)
            S_BOOT:  state_d = S_REQ;
            S_REQ:   state_d = bus.imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = S_DELIV;
                    inst_d  = bus.imem_rsp_data;
                end
            end
            S_DELIV: begin
                if (bus.inst_ready) begin
                    instret_d = instret_q + 32'd1;
                    // halt takes priority, so a misaligned next_pc is never latched on a halting instruction
                    if (halt) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d    = next_pc;
                        state_d = (next_pc[1:0] != 2'b00) ? S_ERR : S_REQ;
                    end
                end
            end
            default: state_d = state_q;
        endcase
        req_valid_d  = (state_d == S_REQ);
        inst_valid_d = (state_d == S_DELIV);
        halted_d     = (state_d == S_HALTED);
        err_d        = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            instret_q    <= '0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            instret_q    <= instret_d;
            req_valid_q  <= req_valid_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
            err_q        <= err_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.pc             = pc_q;
    assign halted             = halted_q;
    assign misalign_err       = err_q;
    assign instret            = instret_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench with a 1-cycle-response memory model for pc_fetch_unit
module tb_pc_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] next_pc = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic        misalign_err;
    logic [31:0] instret;
    logic        mem_stall = 1'b0;
    logic        inj_rsp = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          req_count = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_instret = '0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    int          req_cyc_q[$];

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .next_pc     (next_pc),
        .halt        (halt),
        .halted      (halted),
        .misalign_err(misalign_err),
        .instret     (instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // memory model: acts 1 time unit after each falling edge so scenario drives settle first
    initial begin
        logic [31:0] exp_a;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.imem_rsp_valid = pend || inj_rsp;
            bus.imem_rsp_data  = inj_rsp ? 32'hBAD0_BAD0 : mem_word(pend_addr);
            pend = 1'b0;
            bus.imem_req_ready = !mem_stall;
            if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_addr got=%h exp=none", bus.imem_req_addr);
                end else begin
                    exp_a = exp_addr_q.pop_front();
                    if (bus.imem_req_addr !== exp_a) begin
                        errors++;
                        $display("FAIL req_addr got=%h exp=%h", bus.imem_req_addr, exp_a);
                    end
                end
                exp_inst_q.push_back(mem_word(bus.imem_req_addr));
                req_cyc_q.push_back(cyc);
                req_count++;
                pend      = 1'b1;
                pend_addr = bus.imem_req_addr;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.inst_ready = 1'b0;
        halt           = 1'b0;
        next_pc        = '0;
        mem_stall      = 1'b0;
        inj_rsp        = 1'b0;
        exp_addr_q.delete();
        exp_inst_q.delete();
        req_cyc_q.delete();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.imem_req_valid, bus.inst_valid, bus.inst, bus.pc, halted, misalign_err, instret}
            !== {2'b00, 32'h0, RPC, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_vals got rv=%b iv=%b inst=%h pc=%h h=%b e=%b ir=%h exp pc=%h others 0",
                     bus.imem_req_valid, bus.inst_valid, bus.inst, bus.pc, halted, misalign_err, instret, RPC);
        end
        exp_pc      = RPC;
        exp_instret = '0;
        exp_addr_q.push_back(RPC);
        rst_n = 1'b1;
    endtask

    task automatic wait_inst(input int max);
        int n = 0;
        while (bus.inst_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL inst_timeout got inst_valid=%b exp=1", bus.inst_valid);
        end
    endtask

    task automatic accept(input logic [31:0] npc, input logic hlt);
        logic [31:0] ei;
        checks++;
        if (bus.pc !== exp_pc || bus.imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL acc_pc got pc=%h addr=%h exp=%h", bus.pc, bus.imem_req_addr, exp_pc);
        end
        checks++;
        if (exp_inst_q.size() == 0) begin
            errors++;
            $display("FAIL acc_inst got=%h exp=none", bus.inst);
        end else begin
            ei = exp_inst_q.pop_front();
            if (bus.inst !== ei) begin
                errors++;
                $display("FAIL acc_inst got=%h exp=%h", bus.inst, ei);
            end
        end
        bus.inst_ready = 1'b1;
        next_pc        = npc;
        halt           = hlt;
        exp_instret    = exp_instret + 32'd1;
        if (!hlt) begin
            exp_pc = npc;
            if (npc[1:0] == 2'b00) exp_addr_q.push_back(npc);
        end
        @(negedge clk);
        // junk next_pc/halt outside the accept cycle must be ignored
        bus.inst_ready = 1'b0;
        next_pc        = 32'hDEAD_BEEF;
        halt           = 1'b1;
        checks++;
        if (bus.inst_valid !== 1'b0 || instret !== exp_instret || bus.pc !== exp_pc) begin
            errors++;
            $display("FAIL acc_after got iv=%b instret=%h pc=%h exp iv=0 instret=%h pc=%h",
                     bus.inst_valid, instret, bus.pc, exp_instret, exp_pc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin
            errors++;
            $display("FAIL first_req got v=%b addr=%h exp v=1 addr=%h", bus.imem_req_valid, bus.imem_req_addr, RPC);
        end
        @(negedge clk);
        checks++;
        if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL wait_valids got rv=%b iv=%b exp 0 0", bus.imem_req_valid, bus.inst_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.pc !== RPC) begin
            errors++;
            $display("FAIL first_inst got iv=%b pc=%h exp iv=1 pc=%h", bus.inst_valid, bus.pc, RPC);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            wait_inst(20);
            accept(exp_pc + 32'd4, 1'b0);
        end
        checks++;
        if (instret !== 32'd4) begin
            errors++;
            $display("FAIL seq_instret got=%h exp=4", instret);
        end
        checks++;
        if (req_cyc_q.size() < 4) begin
            errors++;
            $display("FAIL seq_reqs got=%0d exp>=4", req_cyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (req_cyc_q[i] - req_cyc_q[i-1] != 3) begin
                    errors++;
                    $display("FAIL seq_spacing idx=%0d got=%0d exp=3", i, req_cyc_q[i] - req_cyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          n0;
        logic [31:0] i0;
        logic [31:0] held_inst;
        logic [31:0] held_pc;
        mem_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h1010) begin
                errors++;
                $display("FAIL bp_req got v=%b addr=%h exp v=1 addr=00001010", bus.imem_req_valid, bus.imem_req_addr);
            end
            @(negedge clk);
        end
        n0 = req_count;
        i0 = instret;
        mem_stall = 1'b0;
        wait_inst(20);
        checks++;
        if (req_count != n0 + 1) begin
            errors++;
            $display("FAIL bp_req_count got=%0d exp=%0d", req_count, n0 + 1);
        end
        held_inst = bus.inst;
        held_pc   = bus.pc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== held_inst || bus.pc !== held_pc || bus.imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got iv=%b inst=%h pc=%h rv=%b exp iv=1 inst=%h pc=%h rv=0",
                         bus.inst_valid, bus.inst, bus.pc, bus.imem_req_valid, held_inst, held_pc);
            end
        end
        accept(exp_pc + 32'd4, 1'b0);
        checks++;
        if (instret !== i0 + 32'd1 || req_count != n0 + 1) begin
            errors++;
            $display("FAIL bp_once got instret=%h reqs=%0d exp instret=%h reqs=%0d", instret, req_count, i0 + 32'd1, n0 + 1);
        end
    endtask

    task automatic test_branch_misalign();
        wait_inst(20);
        accept(32'h2000, 1'b0);
        wait_inst(20);
        accept(32'h2002, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({misalign_err, halted, bus.imem_req_valid, bus.inst_valid} !== 4'b1000 || bus.pc !== 32'h2002) begin
                errors++;
                $display("FAIL err_state got e=%b h=%b rv=%b iv=%b pc=%h exp e=1 h=0 rv=0 iv=0 pc=00002002",
                         misalign_err, halted, bus.imem_req_valid, bus.inst_valid, bus.pc);
            end
            @(negedge clk);
        end
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL err_pending got=%0d exp=0", exp_addr_q.size());
        end
    endtask

    task automatic test_halt();
        do_reset();
        wait_inst(20);
        accept(32'h3001, 1'b1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({halted, misalign_err, bus.imem_req_valid, bus.inst_valid} !== 4'b1000 || bus.pc !== RPC || instret !== 32'd1) begin
                errors++;
                $display("FAIL halt_state got h=%b e=%b rv=%b iv=%b pc=%h ir=%h exp h=1 e=0 rv=0 iv=0 pc=%h ir=1",
                         halted, misalign_err, bus.imem_req_valid, bus.inst_valid, bus.pc, instret, RPC);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_wait_wrap();
        do_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rw_in_wait got rv=%b iv=%b exp 0 0", bus.imem_req_valid, bus.inst_valid);
        end
        do_reset();
        inj_rsp = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.inst_valid !== 1'b0 || bus.imem_req_addr !== RPC) begin
            errors++;
            $display("FAIL rw_req got rv=%b iv=%b addr=%h exp rv=1 iv=0 addr=%h", bus.imem_req_valid, bus.inst_valid, bus.imem_req_addr, RPC);
        end
        @(negedge clk);
        inj_rsp = 1'b0;
        checks++;
        if ({bus.imem_req_valid, bus.inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rw_ignored got rv=%b iv=%b exp 0 0", bus.imem_req_valid, bus.inst_valid);
        end
        wait_inst(20);
        force dut.instret_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instret_q;
        checks++;
        if (instret !== 32'hFFFF_FFFF || bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_preload got instret=%h iv=%b exp instret=ffffffff iv=1", instret, bus.inst_valid);
        end
        exp_instret = 32'hFFFF_FFFF;
        accept(exp_pc + 32'd4, 1'b0);
        checks++;
        if (instret !== 32'h0) begin
            errors++;
            $display("FAIL wrap got=%h exp=00000000", instret);
        end
    endtask

    initial begin
        bus.inst_ready = 1'b0;
        #2;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_misalign();
        test_halt();
        test_reset_wait_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the RISC-V core.
- Consumes the next-PC value produced by the 32-bit 2:1 next-PC selector (PC+4 vs. branch/jump target).
- Holds the architectural PC, fetches from instruction memory over a valid/ready request port and a response port, and presents each instruction to decode with a valid/ready handshake.
- Also tracks halt, misaligned next-PC and retired-instruction count.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- next_pc  input  32  next PC from the next-PC selector; sampled only on an instruction-accept cycle.
- halt  input  1  decode flags the presented instruction as halting (ecall/ebreak); sampled only on accept.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts request.
- imem_req_addr  output  32  fetch address, always equal to pc.
- imem_rsp_valid  input  1  fetch response valid, single-cycle pulse.
- imem_rsp_data  input  32  fetched instruction word.
- inst_valid  output  1  inst/pc valid for decode.
- inst_ready  input  1  decode/execute consumes the instruction.
- inst  output  32  current instruction.
- pc  output  32  current PC.
- halted  output  1  core halted (sticky).
- misalign_err  output  1  next_pc[1:0] != 0 was taken (sticky).
- instret  output  32  retired-instruction counter.

Behaviour:
- Reset (async, rst_n=0):
  - State BOOT; pc=RESET_PC.
  - imem_req_valid=0, inst_valid=0, inst=0, halted=0, misalign_err=0, instret=0.
  - Any in-flight memory response is abandoned.
- Registers: all state and outputs are registered; imem_req_addr is wired to pc.
- States:
  - BOOT: one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1. Address is held stable until handshake. On imem_req_ready=1, go to WAIT. imem_rsp_valid seen in BOOT/REQ is ignored.
  - WAIT: imem_req_valid=0. Wait indefinitely. On imem_rsp_valid=1, inst<=imem_rsp_data, inst_valid<=1, go to DELIV.
  - DELIV: inst_valid=1; inst and pc held stable while inst_ready=0. On inst_ready=1 (accept):
    - instret<=instret+1, wrapping 32'hFFFF_FFFF to 0.
    - inst_valid<=0.
    - If halt=1: go to HALTED; pc holds.
    - Else pc<=next_pc, then:
      - next_pc[1:0]!=0: go to ERR.
      - Otherwise: go to REQ.
  - HALTED: halted=1; all valids 0; pc and instret frozen; exit only via reset.
  - ERR: misalign_err=1; pc holds the faulting next_pc; all valids 0; exit only via reset.
- Simultaneous events:
  - halt=1 together with a misaligned next_pc on accept: halt wins, misalign_err stays 0.
  - halt and next_pc have no effect outside the accept cycle.
- Latency:
  - Minimum 3 cycles per instruction (REQ+ready → WAIT+rsp → DELIV+ready).
  - First request is asserted in the 2nd cycle after reset release.
- Arithmetic: instret is unsigned 32-bit with no saturation. No PC arithmetic inside the block; pc+4 is computed externally.
- Reset mid-operation (any state): immediately returns to BOOT with the reset values above.

Test Plan:
- Reset with RESET_PC=32'h0000_1000, memory always ready, 1-cycle response → imem_req_addr=0x1000 with valid in cycle 2; inst_valid in cycle 4; pc=0x1000.
- Sequential stream: next_pc=pc+4, inst_ready=1 constantly, 4 instructions → addresses 0x1000/0x1004/0x1008/0x100C fetched in order, one every 3 cycles; instret=4.
- Backpressure: hold imem_req_ready=0 for 5 cycles, then inst_ready=0 for 4 cycles → addr/inst/pc stable throughout; no duplicate request; instret increments exactly once.
- Branch and misalignment: accept with next_pc=0x2000 → next request at 0x2000; later accept with next_pc=0x2002 → misalign_err=1, pc=0x2002, no further requests.
- Halt: accept with halt=1 and next_pc=0x3001 → halted=1, misalign_err=0, pc unchanged, imem_req_valid stays 0 for 20 cycles.
- Reset in WAIT with a response arriving in the cycle after release, plus an instret wrap test from 0xFFFF_FFFF (forced via a preload sequence) → response ignored, state BOOT→REQ at RESET_PC; instret wraps to 0.
